// File: rtl/alu_mac_sequencer.sv
// alu_mac_sequencer: shift-add 8x8 unsigned MAC into a 16-bit accumulator through a shared 8-bit ALU.
// Define ALU_MAC_SAT_EN to saturate the accumulator at 16'hFFFF on overflow instead of wrapping.
module alu_mac_sequencer #(
  parameter logic [3:0] OP_ADD  = 4'd0,
  parameter logic [3:0] OP_ADC  = 4'd1,
  parameter logic [3:0] OP_IDLE = 4'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clr_acc,
  input  logic [7:0]  x_in,
  input  logic [7:0]  c_in,
  output logic        ready,
  output logic        done,
  output logic [15:0] acc_out,
  output logic        ovf,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_cin,
  input  logic [7:0]  alu_out,
  input  logic        alu_cout,
  input  logic        alu_zero
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_ADD_LO = 3'd2;
  localparam logic [2:0] S_ADD_HI = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  logic [2:0]  state_q, state_d;
  logic [15:0] acc_q, acc_d, mc_q, mc_d;
  logic [7:0]  c_q, c_d;
  logic        carry_q, carry_d, ovf_q, ovf_d;
  logic        unused_zero;
  assign unused_zero = alu_zero;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    c_d     = c_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    alu_op  = OP_IDLE;
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_cin = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        mc_d    = {8'h00, x_in};
        c_d     = c_in;
        acc_d   = clr_acc ? 16'h0000 : acc_q;
        ovf_d   = clr_acc ? 1'b0 : ovf_q;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        state_d = (c_q == 8'h00) ? S_DONE : (c_q[0] ? S_ADD_LO : S_SCAN);
        mc_d    = (c_q != 8'h00 && !c_q[0]) ? mc_q << 1 : mc_q;
        c_d     = (c_q != 8'h00 && !c_q[0]) ? c_q >> 1 : c_q;
      end
      S_ADD_LO: begin
        alu_op     = OP_ADD;
        alu_a      = acc_q[7:0];
        alu_b      = mc_q[7:0];
        acc_d[7:0] = alu_out;
        carry_d    = alu_cout;
        state_d    = S_ADD_HI;
      end
      S_ADD_HI: begin
        alu_op      = OP_ADC;
        alu_a       = acc_q[15:8];
        alu_b       = mc_q[15:8];
        alu_cin     = carry_q;
        acc_d[15:8] = alu_out;
        ovf_d       = ovf_q | alu_cout;
`ifdef ALU_MAC_SAT_EN
        acc_d       = alu_cout ? 16'hFFFF : acc_d;
`endif
        mc_d        = mc_q << 1;
        c_d         = c_q >> 1;
        state_d     = S_SCAN;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= 16'h0000;
      mc_q    <= 16'h0000;
      c_q     <= 8'h00;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end
  assign ready   = state_q == S_IDLE;
  assign done    = state_q == S_DONE;
  assign acc_out = acc_q;
  assign ovf     = ovf_q;
endmodule

// File: doc/alu_mac_sequencer.md
Name: alu_mac_sequencer

Overview:
- Multi-cycle controller that drives the shared 8-bit combinational ALU to compute a 16-bit multiply-accumulate: acc <= acc + x*c, unsigned.
- Uses the shift-add method, LSB-first over the coefficient. The ALU performs every add as a low-byte ADD followed by a high-byte ADC. The controller keeps the shifted multiplicand and the accumulator.
- Sits between the FIR tap sequencer (start/done handshake) and the ALU instance (op/operand drive, result capture).

Parameters:
OP_ADD, 4'd0, ALU opcode for A+B with carry-out
OP_ADC, 4'd1, ALU opcode for A+B+cin with carry-out
OP_IDLE, 4'd4, opcode driven when the ALU is not in use (AND, side-effect free)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when ready=1
clr_acc  input  1  sampled with accepted start; 1 = clear acc and ovf before accumulating
x_in  input  8  multiplicand (sample)
c_in  input  8  multiplier (coefficient)
ready  output  1  high only in IDLE
done  output  1  one-cycle pulse, result valid
acc_out  output  16  accumulator
ovf  output  1  sticky carry-out of 16-bit accumulation
alu_a  output  8  ALU operand A
alu_b  output  8  ALU operand B
alu_op  output  4  ALU opcode
alu_cin  output  1  ALU carry-in
alu_out  input  8  ALU result
alu_cout  input  1  ALU carry-out
alu_zero  input  1  ALU zero flag (unused; must not affect behaviour)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, ovf=0, done=0, ready=1; internal mc (16b), c_reg, carry cleared.
- Reset asserted mid-operation aborts immediately. The partial result is discarded; acc reads 0 after reset.
- ALU drive is combinational from state. It defaults to op=OP_IDLE, a=b=0, cin=0 in every state except ADD_LO and ADD_HI. ALU results are captured on the clock edge ending that cycle.
- IDLE:
  - start=1 loads mc={8'h00,x_in} and c_reg=c_in; if clr_acc=1, acc<=0 and ovf<=0.
  - Next state is SCAN. start while not IDLE is ignored.
- SCAN:
  - c_reg==0 -> DONE.
  - else c_reg[0]=1 -> ADD_LO.
  - else mc<=mc<<1, c_reg<=c_reg>>1, stay in SCAN.
- ADD_LO:
  - Drive op=OP_ADD, a=acc[7:0], b=mc[7:0], cin=0.
  - Capture acc[7:0]<=alu_out and carry<=alu_cout. Next state is ADD_HI.
- ADD_HI:
  - Drive op=OP_ADC, a=acc[15:8], b=mc[15:8], cin=carry.
  - Capture acc[15:8]<=alu_out. If alu_cout=1, ovf<=1 (acc wraps mod 2^16).
  - mc<=mc<<1, c_reg<=c_reg>>1. Next state is SCAN.
- DONE: done=1 for exactly this cycle, ready=0. Next state is IDLE, where ready=1 the following cycle.
- mc shift drops bits beyond bit 15. This cannot occur for 8-bit operands, so no check is required.
- Latency: the accepting edge is cycle 0. done is high in cycle L = (msb_index(c)+1) + 2*popcount(c) + 2, where the first term is 0 for c=0.
  - Examples: c=0 -> 2; c=1 -> 5; c=0xFF -> 26 (max).
- Back-to-back: start may be accepted in the first IDLE cycle after DONE.
- acc_out and ovf hold between operations. Intermediate values are visible during operation; only the value at done is architectural.

Optional Feature:
- Macro ALU_MAC_SAT_EN.
- Defined: in ADD_HI, alu_cout=1 forces acc<=16'hFFFF (both bytes) and sets ovf. Later adds keep acc at FFFF.
- Undefined: wrap-around as above; ovf still set.
- Latency is identical in both builds.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> acc_out=0, ovf=0, done=0, ready=1, alu_op=4'd4; repeat mid-operation (c=0xFF, reset at cycle 10) -> same values immediately.
- start, clr_acc=1, x=3, c=5 -> done at cycle 9, acc_out=16'h000F, ovf=0; alu_op sequence contains exactly two ADD/ADC pairs.
- Then clr_acc=0, x=0xFF, c=0xFF -> done at cycle 26, acc_out=16'hFE10, ovf=0.
- c=0, x=0xAA -> done at cycle 2, acc_out unchanged at 16'hFE10, alu_op never 0/1; start pulsed during busy is ignored (no second done).
- From 0xFE10: x=0xFF, c=0x02 -> done at cycle 6, acc_out=16'h000E and ovf=1 (with ALU_MAC_SAT_EN: 16'hFFFF, ovf=1); next start with clr_acc=1, x=1, c=1 -> acc_out=16'h0001, ovf=0.
- Back-to-back: start held high -> second operation accepted the cycle after the DONE cycle, ready low exactly from the accept cycle+1 through DONE.
